// File: rtl/byte_word_packer.sv
// byte_word_packer: packs little-endian bytes into N-byte words, with
// zero-padded flush of partial words and a single output holding slot.
module byte_word_packer #(
  parameter  int unsigned BYTES_PER_WORD = 4,
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_valid_i,
  input  logic [7:0]                  i_data_i,
  output logic                        i_ready_o,
  input  logic                        flush_i,
  input  logic                        e_ready_i,
  output logic                        e_valid_o,
  output logic [8*BYTES_PER_WORD-1:0] e_data_o,
  output logic [CNT_W-1:0]            e_bytes_o
);

  localparam int unsigned N = BYTES_PER_WORD;
  localparam int unsigned W = 8 * N;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N - 1);

  logic [W-1:0]     acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
  logic             flush_pend_q, flush_pend_d;

  logic             acc_byte;
  logic             slot_free;
  logic             has_data;
  logic             word_done;
  logic             flush_fire;
  logic [W-1:0]     acc_merged;

  // Handshake and event qualifiers; ready only stalls when the last lane
  // would complete a word into an occupied slot, or a flush is waiting.
  always_comb begin
    slot_free  = !out_valid_q || e_ready_i;
    i_ready_o  = !flush_pend_q && ((cnt_q != LAST_LANE) || slot_free);
    acc_byte   = i_valid_i && i_ready_o;
    has_data   = (cnt_q != '0) || acc_byte;
    word_done  = acc_byte && (cnt_q == LAST_LANE);
    flush_fire = (flush_i || flush_pend_q) && has_data && slot_free;
  end

  // Accumulator view including any byte accepted this cycle in lane cnt.
  always_comb begin
    acc_merged = acc_q;
    for (int unsigned l = 0; l < N; l++) begin
      if (acc_byte && (cnt_q == CNT_W'(l))) begin
        acc_merged[8*l +: 8] = i_data_i;
      end
    end
  end

  // Next-state: accept, word complete / flush load, slot drain, flush deferral.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_bytes_d  = out_bytes_q;
    flush_pend_d = flush_pend_q;

    if (acc_byte) begin
      acc_d = acc_merged;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (word_done || flush_fire) begin
      // A load always wins over a same-cycle drain so the slot stays valid.
      out_data_d   = acc_merged;
      out_bytes_d  = cnt_q + CNT_W'(acc_byte);
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (out_valid_q && e_ready_i) begin
        out_valid_d = 1'b0;
      end
      if (flush_i && has_data && !slot_free) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign e_valid_o = out_valid_q;
  assign e_data_o  = out_data_q;
  assign e_bytes_o = out_bytes_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer (N = 4).
module tb_byte_word_packer;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef struct packed {
    logic [8*N-1:0]   data;
    logic [CNT_W-1:0] bytes;
  } word_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_valid_i;
  logic [7:0]       i_data_i;
  logic             i_ready_o;
  logic             flush_i;
  logic             e_ready_i;
  logic             e_valid_o;
  logic [8*N-1:0]   e_data_o;
  logic [CNT_W-1:0] e_bytes_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  word_t sb[$];
  int    xfer_cyc[$];
  word_t exp_w;

  logic [8*N-1:0] mdl_acc;
  int             mdl_cnt;

  logic             prev_stall;
  logic [8*N-1:0]   prev_data;
  logic [CNT_W-1:0] prev_bytes;

  always #5 clk = ~clk;

  byte_word_packer #(.BYTES_PER_WORD(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_ready_o (i_ready_o),
    .flush_i   (flush_i),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o),
    .e_bytes_o (e_bytes_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Egress monitor: transfers are compared against the scoreboard in order;
  // a stalled word must stay stable until it is taken.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && e_valid_o) begin
        check_eq("hold_data", 64'(e_data_o), 64'(prev_data));
        check_eq("hold_bytes", 64'(e_bytes_o), 64'(prev_bytes));
      end
      if (e_valid_o && e_ready_i) begin
        check_eq("sb_has_exp", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check_eq("word_data", 64'(e_data_o), 64'(exp_w.data));
          check_eq("word_bytes", 64'(e_bytes_o), 64'(exp_w.bytes));
        end
        xfer_cyc.push_back(cyc);
      end
      prev_stall = e_valid_o && !e_ready_i;
      prev_data  = e_data_o;
      prev_bytes = e_bytes_o;
    end
  end

  task automatic push_word();
    sb.push_back('{data: mdl_acc, bytes: CNT_W'(mdl_cnt)});
    mdl_acc = '0;
    mdl_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte (optionally with a same-cycle flush) until accepted.
  task automatic send_byte(input logic [7:0] b, input logic fl, output int waited);
    waited    = 0;
    i_valid_i = 1'b1;
    i_data_i  = b;
    flush_i   = fl;
    #1;
    while (!i_ready_o && waited < 40) begin
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      #1;
      waited++;
    end
    if (!i_ready_o) begin
      check_eq("send_timeout", 64'(i_ready_o), 64'd1);
      i_valid_i = 1'b0;
      flush_i   = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_valid_i = 1'b0;
      flush_i   = 1'b0;
      mdl_acc[8*mdl_cnt +: 8] = b;
      mdl_cnt++;
      if (mdl_cnt == N || (fl && waited == 0)) push_word();
    end
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    if (mdl_cnt != 0) push_word();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    e_ready_i = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset_n   = 1'b0;
    i_valid_i = 1'b0;
    i_data_i  = '0;
    flush_i   = 1'b0;
    e_ready_i = 1'b0;
    mdl_acc   = '0;
    mdl_cnt   = 0;
    prev_stall = 1'b0;

    #12;
    check_eq("rst_valid", 64'(e_valid_o), 64'd0);
    check_eq("rst_data", 64'(e_data_o), 64'd0);
    check_eq("rst_bytes", 64'(e_bytes_o), 64'd0);
    check_eq("rst_ready", 64'(i_ready_o), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Back-to-back stream, consumer always ready.
    e_ready_i = 1'b1;
    xfer_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      send_byte(8'(17 * (k + 1)), 1'b0, w);
      check_eq("b2b_no_stall", 64'(w), 64'd0);
      if (k == 3) begin
        check_eq("b2b_w0_valid", 64'(e_valid_o), 64'd1);
        check_eq("b2b_w0_data", 64'(e_data_o), 64'h44332211);
        check_eq("b2b_w0_bytes", 64'(e_bytes_o), 64'd4);
      end
    end
    check_eq("b2b_w1_valid", 64'(e_valid_o), 64'd1);
    check_eq("b2b_w1_data", 64'(e_data_o), 64'h88776655);
    drain("b2b_drain");
    check_eq("b2b_spacing", 64'((xfer_cyc.size() >= 2) ? (xfer_cyc[1] - xfer_cyc[0]) : -1), 64'd4);

    // Backpressure: slot held, three bytes absorbed, fourth waits.
    e_ready_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      send_byte(8'(k), 1'b0, w);
      check_eq("bp_absorb", 64'(w), 64'd0);
    end
    fork
      begin
        send_byte(8'h08, 1'b0, w);
      end
      begin
        #2;
        check_eq("bp_ready_low", 64'(i_ready_o), 64'd0);
        check_eq("bp_held_data", 64'(e_data_o), 64'h04030201);
        check_eq("bp_held_valid", 64'(e_valid_o), 64'd1);
        repeat (3) begin
          @(posedge clk);
          #2;
          check_eq("bp_ready_low", 64'(i_ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        e_ready_i = 1'b1;
      end
    join
    check_eq("bp_08_waited", 64'(w > 0), 64'd1);
    drain("bp_drain");

    // Reset mid-stream with a held word and two bytes accumulated.
    e_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) send_byte(8'(8'hA1 + k), 1'b0, w);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(e_valid_o), 64'd0);
    check_eq("mid_rst_data", 64'(e_data_o), 64'd0);
    check_eq("mid_rst_bytes", 64'(e_bytes_o), 64'd0);
    check_eq("mid_rst_ready", 64'(i_ready_o), 64'd1);
    sb.delete();
    mdl_acc = '0;
    mdl_cnt = 0;
    tick();
    reset_n = 1'b1;
    tick();
    e_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(8'(17 * (k + 1)), 1'b0, w);
    check_eq("post_rst_data", 64'(e_data_o), 64'h44332211);
    drain("rst_drain");

    // Flush of a partial word, then an empty flush.
    send_byte(8'hAA, 1'b0, w);
    send_byte(8'hBB, 1'b0, w);
    do_flush();
    check_eq("flush_valid", 64'(e_valid_o), 64'd1);
    check_eq("flush_data", 64'(e_data_o), 64'h0000BBAA);
    check_eq("flush_bytes", 64'(e_bytes_o), 64'd2);
    do_flush();
    check_eq("empty_flush_none", 64'(e_valid_o), 64'd0);
    tick();
    check_eq("empty_flush_none2", 64'(e_valid_o), 64'd0);
    drain("flush_drain");

    // Flush coinciding with an accepted byte, and with a word-completing byte.
    send_byte(8'hAA, 1'b0, w);
    send_byte(8'hCC, 1'b1, w);
    check_eq("flush_same_data", 64'(e_data_o), 64'h0000CCAA);
    check_eq("flush_same_bytes", 64'(e_bytes_o), 64'd2);
    for (int k = 1; k <= 3; k++) send_byte(8'(k), 1'b0, w);
    send_byte(8'h04, 1'b1, w);
    check_eq("flush_full_data", 64'(e_data_o), 64'h04030201);
    check_eq("flush_full_bytes", 64'(e_bytes_o), 64'd4);
    tick();
    check_eq("flush_full_single", 64'(e_valid_o), 64'd0);
    drain("flush_same_drain");

    // Deferred flush while the slot is blocked.
    e_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(8'(8'h10 + k), 1'b0, w);
    send_byte(8'h20, 1'b0, w);
    do_flush();
    #1;
    check_eq("defer_ready_low", 64'(i_ready_o), 64'd0);
    check_eq("defer_held_data", 64'(e_data_o), 64'h13121110);
    repeat (3) begin
      tick();
      #1;
      check_eq("defer_ready_low", 64'(i_ready_o), 64'd0);
    end
    tick();
    e_ready_i = 1'b1;
    #1;
    check_eq("defer_pend_ready", 64'(i_ready_o), 64'd0);
    tick();
    check_eq("defer_valid", 64'(e_valid_o), 64'd1);
    check_eq("defer_data", 64'(e_data_o), 64'h00000020);
    check_eq("defer_bytes", 64'(e_bytes_o), 64'd1);
    #1;
    check_eq("defer_ready_back", 64'(i_ready_o), 64'd1);
    drain("defer_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Width up-converter placed directly downstream of the 8-bit skid buffer. It consumes the buffer's byte stream over a valid/ready handshake and packs `BYTES_PER_WORD` consecutive bytes, little-endian, into one output word. A flush request emits a zero-padded partial word that carries a byte count. A single output holding register decouples the word consumer, and full byte-per-cycle throughput is sustained while the consumer stays ready.

## Interface
- `BYTES_PER_WORD`, default 4: bytes per output word; legal range 2..8.
- `CNT_W`, derived as `$clog2(BYTES_PER_WORD+1)`: width of the byte count. Not overridable.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `i_valid_i` in 1: ingress byte valid, driven by the upstream skid buffer's `e_valid_o`.
- `i_data_i` in 8: ingress byte.
- `i_ready_o` out 1: ingress ready.
- `flush_i` in 1: single-cycle flush request pulse.
- `e_ready_i` in 1: egress consumer ready.
- `e_valid_o` out 1: egress word valid; driven directly from a register.
- `e_data_o` out 8*BYTES_PER_WORD: egress word. The first-received byte occupies `[7:0]`.
- `e_bytes_o` out CNT_W: number of valid bytes in `e_data_o`, range 1..BYTES_PER_WORD.

## Operation
- **State registers:**
  - `acc`: accumulator, 8*N bits.
  - `cnt`: bytes held in `acc`, range 0..N-1.
  - `out_valid`, `out_data`, `out_bytes`: the output slot.
  - `flush_pend`: 1 bit.
- **Derived signals:**
  - `acc_byte = i_valid_i && i_ready_o`.
  - `slot_free = !out_valid || e_ready_i`.
  - `i_ready_o = !flush_pend && ((cnt != N-1) || slot_free)`. This is a combinational path from `e_ready_i`, and that path is permitted.
- **Byte accept:**
  - The byte is written into lane `cnt` of `acc`.
  - `cnt` increments by 1.
- **Word complete:** occurs when `acc_byte` is set and `cnt == N-1`.
  - `out_data` is loaded with `acc` plus the new byte in lane N-1.
  - `out_bytes` is set to N and `out_valid` to 1.
  - `acc` and `cnt` are cleared to 0.
- **Flush:**
  - Flush fires when `(flush_i || flush_pend) && (cnt != 0 || acc_byte) && slot_free`.
  - `out_data` receives the accumulated lanes, including a byte accepted in the same cycle. Unfilled lanes are 0.
  - `out_bytes` receives `cnt + acc_byte`, and `out_valid` is set to 1.
  - `acc`, `cnt` and `flush_pend` are cleared.
  - If word-complete and flush occur in the same cycle, only one word is emitted, with `e_bytes_o = N`, and the flush is consumed.
- **Flush deferral:**
  - If `flush_i` is high, data is present (`cnt != 0 || acc_byte`) and `!slot_free`, `flush_pend` is set to 1.
  - While `flush_pend` is high, `i_ready_o` is 0.
- **Empty flush:** a `flush_i` pulse with `cnt == 0` and no byte accepted that cycle is dropped. No zero-length word is emitted.
- **Egress:**
  - When `out_valid && e_ready_i`, the slot drains.
  - `out_valid` clears unless a new word or flush loads the slot in the same cycle. Load takes priority, so the slot stays valid with the new contents.
- **Holding rule:** while `e_valid_o && !e_ready_i`, `e_data_o` and `e_bytes_o` are held stable.
- **Invariants:** no byte is ever dropped or duplicated, and byte order is preserved.

## Timing
- **Reset values:**
  - While `reset_n` is low: `e_valid_o=0`, `e_data_o=0`, `e_bytes_o=0`, `acc=0`, `cnt=0`, `flush_pend=0`.
  - `i_ready_o` evaluates to 1.
- **Latency:** the byte that completes a word, accepted at edge t, gives `e_valid_o=1` in the cycle after edge t.
- **Flush latency:** one cycle when the slot is free. Otherwise the flush fires in the first cycle where `slot_free` is true.
- **Throughput:** with `e_ready_i` held at 1, one byte is accepted every cycle and one word is emitted every N cycles, with no bubbles.
- **Backpressure stall:** with the slot full and blocked, the accumulator continues to absorb N-1 bytes, then `i_ready_o` drops.
- **Reset mid-operation:** an asynchronous clear of all state.
  - Partial words and pending flushes are discarded.
  - The first byte after reset release goes into lane 0.

## Test plan
- **Reset:** assert `reset_n=0` mid-stream with `cnt=2` and `out_valid=1`. Required: `e_valid_o=0`, `e_data_o=0`, `e_bytes_o=0` and `i_ready_o=1` immediately. After release, 0x11 0x22 0x33 0x44 yields `0x44332211`.
- **Back-to-back stream:** N=4, `e_ready_i=1`, bytes 0x11..0x88 on consecutive cycles. Required: `e_data_o=0x44332211` with `e_bytes_o=4` one cycle after 0x44, then `0x88776655` exactly 4 cycles later. `i_ready_o` never drops.
- **Backpressure:** `e_ready_i=0`, offer 0x01..0x08. Required:
  - Word `0x04030201` is held.
  - 0x05..0x07 are absorbed.
  - `i_ready_o=0` while 0x08 is waiting.
  - After raising `e_ready_i`, the outputs are `0x04030201` then `0x08070605`, with no loss.
- **Flush basic:** send 0xAA 0xBB, then a `flush_i` pulse with no byte. Required: `e_data_o=0x0000BBAA`, `e_bytes_o=2`. A further `flush_i` pulse with `cnt=0` produces no word.
- **Flush with same-cycle byte:** after 0xAA, `flush_i` coincides with accepted 0xCC. Required: `0x0000CCAA`, `e_bytes_o=2`. With 3 bytes held, a flush coinciding with the 4th byte yields a single word with `e_bytes_o=4`.
- **Deferred flush:** with the slot blocked, pulse `flush_i` when `cnt=1`. Required:
  - `flush_pend=1` and `i_ready_o=0` until `e_ready_i` rises.
  - The partial word is emitted, with `e_bytes_o=1`, on the cycle after the slot drains.
  - `i_ready_o` returns to 1.
